// File: rtl/shift_deserializer_if.sv
// Bundle of the serial input side, parallel output handshake and status lines
// of shift_deserializer. The slave modport is the deserializer's view. The master
// modport is the view of the environment: the serial source and the word consumer.
interface shift_deserializer_if #(
   parameter int WIDTH = 8
);
   logic             serial_in;
   logic             serial_valid;
   logic             dir;
   logic             sync;
   logic [WIDTH-1:0] dataout;
   logic             out_valid;
   logic             out_ready;
   logic             busy;
   logic             overrun;
   logic             clr_overrun;
   logic             parity_err;

   modport master (
      output serial_in, serial_valid, dir, sync, out_ready, clr_overrun,
      input  dataout, out_valid, busy, overrun, parity_err
   );

   modport slave (
      input  serial_in, serial_valid, dir, sync, out_ready, clr_overrun,
      output dataout, out_valid, busy, overrun, parity_err
   );
endinterface

// File: rtl/shift_deserializer.sv
// shift_deserializer: receive end of the serial shift path. Assembles WIDTH
// serial bits (MSB-first or LSB-first, chosen by dir on the first bit of each
// word) into a parallel word. The word is held on a valid/ready output until
// the consumer takes it. A word that completes while the previous one is still
// unconsumed is dropped, and a sticky overrun flag records the loss.
// Optional feature macro: PARITY_CHECK_EN. When it is defined, each word carries
// one extra even-parity bit, and parity_err reports the check result for the
// word on dataout. When it is undefined, parity_err is tied to 0.
module shift_deserializer #(
   parameter int WIDTH = 8
) (
   input  logic                clk,
   input  logic                reset,
   shift_deserializer_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] count, count_nx;
   logic [WIDTH-1:0] sh, sh_nx;
   logic             dir_lat, dir_lat_nx;
   logic             complete;
   logic [WIDTH-1:0] word;
   logic [WIDTH-1:0] dataout_q;
   logic             out_valid_q;
   logic             overrun_q;
`ifdef PARITY_CHECK_EN
   logic             word_perr;
   logic             parity_err_q;
`endif

   // dir = 0 shifts toward the MSB (first bit ends up in bit WIDTH-1);
   // dir = 1 shifts toward the LSB (first bit ends up in bit 0).
   function automatic logic [WIDTH-1:0] shift_bit(input logic [WIDTH-1:0] s,
                                                  input logic b,
                                                  input logic d);
      return d ? {b, s[WIDTH-1:1]} : {s[WIDTH-2:0], b};
   endfunction

   // FSM state, bit count, shift register and latched direction
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         count   <= '0;
         sh      <= '0;
         dir_lat <= 1'b0;
      end else begin
         state   <= state_nx;
         count   <= count_nx;
         sh      <= sh_nx;
         dir_lat <= dir_lat_nx;
      end
   end

   // Next state, bit collection and word-complete detection. sync wins over a
   // bit arriving in the same cycle, so that bit is discarded.
   always_comb begin
      state_nx   = state;
      count_nx   = count;
      sh_nx      = sh;
      dir_lat_nx = dir_lat;
      complete   = 1'b0;
      word       = sh;
`ifdef PARITY_CHECK_EN
      word_perr  = 1'b0;
`endif
      if (bus.sync) begin
         state_nx = IDLE;
         count_nx = '0;
      end else if (bus.serial_valid) begin
         unique case (state)
            IDLE: begin
               dir_lat_nx = bus.dir;
               sh_nx      = shift_bit(sh, bus.serial_in, bus.dir);
               count_nx   = CNT_W'(1);
               state_nx   = SHIFT;
            end
            SHIFT: begin
               sh_nx = shift_bit(sh, bus.serial_in, dir_lat);
               if (count == LAST_BIT) begin
`ifdef PARITY_CHECK_EN
                  count_nx = count + CNT_W'(1);
                  state_nx = PARITY;
`else
                  complete = 1'b1;
                  word     = sh_nx;
                  count_nx = '0;
                  state_nx = IDLE;
`endif
               end else begin
                  count_nx = count + CNT_W'(1);
               end
            end
`ifdef PARITY_CHECK_EN
            PARITY: begin
               complete  = 1'b1;
               word      = sh;
               word_perr = ^{sh, bus.serial_in};
               count_nx  = '0;
               state_nx  = IDLE;
            end
`endif
            default: begin
               count_nx = '0;
               state_nx = IDLE;
            end
         endcase
      end
   end

   // Output word holding register, valid/ready handshake and sticky overrun.
   // A completed word loads only if the register is empty or is being consumed
   // on this edge; otherwise it is dropped. A set of overrun on the same edge
   // as clr_overrun takes priority over the clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dataout_q    <= '0;
         out_valid_q  <= 1'b0;
         overrun_q    <= 1'b0;
`ifdef PARITY_CHECK_EN
         parity_err_q <= 1'b0;
`endif
      end else begin
         if (bus.clr_overrun) begin
            overrun_q <= 1'b0;
         end
         if (complete) begin
            if (!out_valid_q || bus.out_ready) begin
               dataout_q    <= word;
               out_valid_q  <= 1'b1;
`ifdef PARITY_CHECK_EN
               parity_err_q <= word_perr;
`endif
            end else begin
               overrun_q <= 1'b1;
            end
         end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign bus.dataout    = dataout_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.overrun    = overrun_q;
   assign bus.busy       = (state != IDLE);
`ifdef PARITY_CHECK_EN
   assign bus.parity_err = parity_err_q;
`else
   assign bus.parity_err = 1'b0;
`endif
endmodule
